// File: rtl/full_register_n_pkg.sv
// Shared types for full_register_n: FSM state, single-cycle operation codes
// and serial shift direction constants.
package full_register_n_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Operation selected for the current edge; OP_NONE holds value and carry.
  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_CLR  = 3'd1,
    OP_LD   = 3'd2,
    OP_INC  = 3'd3,
    OP_DEC  = 3'd4,
    OP_SHR  = 3'd5,
    OP_SHL  = 3'd6
  } op_e;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/full_register_n_if.sv
// Operation/handshake bundle for full_register_n.
// master: drives ld/clr/inc/dec/shr/shl/input_carry/data_in/start/shamt/dir
//         (and rot when FULL_REGISTER_N_ROTATE_EN is defined).
// slave : drives data_out/output_carry/zero/busy/done.
interface full_register_n_if #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = 4
);
  logic               ld;
  logic               clr;
  logic               inc;
  logic               dec;
  logic               shr;
  logic               shl;
  logic               input_carry;
  logic [WIDTH-1:0]   data_in;
  logic               start;
  logic [SHAMT_W-1:0] shamt;
  logic               dir;
`ifdef FULL_REGISTER_N_ROTATE_EN
  logic               rot;
`endif
  logic [WIDTH-1:0]   data_out;
  logic               output_carry;
  logic               zero;
  logic               busy;
  logic               done;

  modport master (
    output
`ifdef FULL_REGISTER_N_ROTATE_EN
           rot,
`endif
           ld, clr, inc, dec, shr, shl, input_carry, data_in, start, shamt, dir,
    input  data_out, output_carry, zero, busy, done
  );

  modport slave (
    input
`ifdef FULL_REGISTER_N_ROTATE_EN
           rot,
`endif
           ld, clr, inc, dec, shr, shl, input_carry, data_in, start, shamt, dir,
    output data_out, output_carry, zero, busy, done
  );
endinterface

// File: rtl/full_register_n_step.sv
// Combinational next-value / next-carry unit shared by the single-cycle ops
// and the serial shift engine.
// Ports: op (operation), cur_data/cur_carry (current state), data_in,
//        input_carry, rot (rotate instead of shifting in input_carry),
//        nxt_data_c/nxt_carry_c (next state).
module full_register_n_step
  import full_register_n_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] cur_data,
  input  logic             cur_carry,
  input  logic [WIDTH-1:0] data_in,
  input  logic             input_carry,
  input  logic             rot,
  output logic [WIDTH-1:0] nxt_data_c,
  output logic             nxt_carry_c
);
  logic [WIDTH:0] sum;

  always_comb begin
    nxt_data_c  = cur_data;
    nxt_carry_c = cur_carry;
    sum         = '0;
    case (op)
      OP_CLR: begin
        nxt_data_c  = '0;
        nxt_carry_c = 1'b0;
      end
      OP_LD: nxt_data_c = data_in;
      OP_INC: begin
        sum         = {1'b0, cur_data} + (WIDTH+1)'(1);
        nxt_data_c  = sum[WIDTH-1:0];
        nxt_carry_c = sum[WIDTH];
      end
      OP_DEC: begin
        nxt_data_c  = cur_data - WIDTH'(1);
        nxt_carry_c = (cur_data == '0);
      end
      // Rotation feeds the outgoing bit back in at the opposite end.
      OP_SHR: begin
        nxt_data_c  = {(rot ? cur_data[0] : input_carry), cur_data[WIDTH-1:1]};
        nxt_carry_c = cur_data[0];
      end
      OP_SHL: begin
        nxt_data_c  = {cur_data[WIDTH-2:0], (rot ? cur_data[WIDTH-1] : input_carry)};
        nxt_carry_c = cur_data[WIDTH-1];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/full_register_n.sv
// WIDTH-bit multifunction register with carry and a multi-cycle serial
// shifter. Single-cycle ops in IDLE by priority clr > ld > inc > dec > shr >
// shl > start; start with non-zero shamt shifts one bit per cycle in SHIFT.
// Ports: clk, rst_n (synchronous, active-low), bus (full_register_n_if.slave).
// Optional macro FULL_REGISTER_N_ROTATE_EN adds bus.rot for rotating shifts.
module full_register_n
  import full_register_n_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = 4
) (
  input logic clk,
  input logic rst_n,
  full_register_n_if.slave bus
);
  state_e             state_q;
  logic [WIDTH-1:0]   data_q;
  logic               carry_q;
  logic               busy_q;
  logic               done_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               dir_q;
  op_e                op_c;
  logic               rot_c;
  logic [WIDTH-1:0]   nxt_data_c;
  logic               nxt_carry_c;

`ifdef FULL_REGISTER_N_ROTATE_EN
  logic rot_q;
  assign rot_c = (state_q == SHIFT) ? rot_q : bus.rot;
`else
  assign rot_c = 1'b0;
`endif

  // Operation select: priority chain in IDLE, clr-or-shift in SHIFT.
  always_comb begin
    op_c = OP_NONE;
    if (state_q == SHIFT) begin
      if (bus.clr)                op_c = OP_CLR;
      else if (dir_q == DIR_LEFT) op_c = OP_SHL;
      else                        op_c = OP_SHR;
    end else begin
      if (bus.clr)      op_c = OP_CLR;
      else if (bus.ld)  op_c = OP_LD;
      else if (bus.inc) op_c = OP_INC;
      else if (bus.dec) op_c = OP_DEC;
      else if (bus.shr) op_c = OP_SHR;
      else if (bus.shl) op_c = OP_SHL;
    end
  end

  full_register_n_step #(.WIDTH(WIDTH)) u_step (
    .op          (op_c),
    .cur_data    (data_q),
    .cur_carry   (carry_q),
    .data_in     (bus.data_in),
    .input_carry (bus.input_carry),
    .rot         (rot_c),
    .nxt_data_c  (nxt_data_c),
    .nxt_carry_c (nxt_carry_c)
  );

  // State, datapath and handshake registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      dir_q   <= DIR_RIGHT;
`ifdef FULL_REGISTER_N_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (op_c != OP_NONE) begin
        data_q  <= nxt_data_c;
        carry_q <= nxt_carry_c;
      end
      case (state_q)
        IDLE: begin
          if (op_c == OP_NONE && bus.start) begin
            if (bus.shamt == '0) begin
              done_q <= 1'b1;
            end else begin
              cnt_q   <= bus.shamt;
              dir_q   <= bus.dir;
`ifdef FULL_REGISTER_N_ROTATE_EN
              rot_q   <= bus.rot;
`endif
              state_q <= SHIFT;
              busy_q  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (bus.clr) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - SHAMT_W'(1);
            // Final shift: value, busy drop and done all land on this edge.
            if (cnt_q == SHAMT_W'(1)) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data_out     = data_q;
  assign bus.output_carry = carry_q;
  assign bus.zero         = (data_q == '0);
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
endmodule

// File: tb/tb_full_register_n.sv
// Randomised self-checking bench for full_register_n (WIDTH=8, SHAMT_W=4)
// against an arithmetic reference model, with directed literal checks.
module tb_full_register_n;
  localparam int unsigned W   = 8;
  localparam int unsigned SW  = 4;
  localparam int unsigned MOD = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  full_register_n_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();

  full_register_n #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model state
  int unsigned m_val = 0;
  bit          m_c = 1'b0;
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int unsigned m_rem = 0;
  bit          m_dir = 1'b0;
  bit          m_rot = 1'b0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_shift(input bit left, input bit rotate);
    bit out_bit;
    bit in_bit;
    if (left) begin
      out_bit = bit'((m_val >> (W - 1)) & 1);
      in_bit  = rotate ? out_bit : bus.input_carry;
      m_val   = ((m_val << 1) | in_bit) % MOD;
    end else begin
      out_bit = bit'(m_val & 1);
      in_bit  = rotate ? out_bit : bus.input_carry;
      m_val   = (m_val >> 1) | (int'(in_bit) << (W - 1));
    end
    m_c = out_bit;
  endtask

  // Advance the model by one rising edge using the inputs present at it.
  task automatic model_edge();
    bit cur_rot;
`ifdef FULL_REGISTER_N_ROTATE_EN
    cur_rot = bus.rot;
`else
    cur_rot = 1'b0;
`endif
    if (!rst_n) begin
      m_val = 0; m_c = 0; m_busy = 0; m_done = 0; m_rem = 0;
      return;
    end
    m_done = 1'b0;
    if (m_busy) begin
      if (bus.clr) begin
        m_val = 0; m_c = 0; m_busy = 0;
      end else begin
        model_shift(m_dir, m_rot);
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 0; m_done = 1;
        end
      end
    end else if (bus.clr) begin
      m_val = 0; m_c = 0;
    end else if (bus.ld) begin
      m_val = bus.data_in;
    end else if (bus.inc) begin
      m_c   = (m_val + 1) >= MOD;
      m_val = (m_val + 1) % MOD;
    end else if (bus.dec) begin
      m_c   = (m_val == 0);
      m_val = (m_val + MOD - 1) % MOD;
    end else if (bus.shr) begin
      model_shift(1'b0, cur_rot);
    end else if (bus.shl) begin
      model_shift(1'b1, cur_rot);
    end else if (bus.start) begin
      if (bus.shamt == 0) m_done = 1;
      else begin
        m_busy = 1; m_rem = bus.shamt; m_dir = bus.dir; m_rot = cur_rot;
      end
    end
  endtask

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("data_out", bus.data_out, m_val);
      chk("output_carry", bus.output_carry, m_c);
      chk("zero", bus.zero, m_val == 0);
      chk("busy", bus.busy, m_busy);
      chk("done", bus.done, m_done);
      chk("done_busy_excl", bus.done & bus.busy, 0);
    end
  end

  task automatic set_idle();
    bus.ld = 0; bus.clr = 0; bus.inc = 0; bus.dec = 0; bus.shr = 0; bus.shl = 0;
    bus.input_carry = 0; bus.data_in = '0; bus.start = 0; bus.shamt = '0; bus.dir = 0;
`ifdef FULL_REGISTER_N_ROTATE_EN
    bus.rot = 0;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic expect_out(input string name, input int unsigned d, input bit c,
                            input bit b, input bit dn);
    chk({name, ".data"}, bus.data_out, d);
    chk({name, ".carry"}, bus.output_carry, c);
    chk({name, ".busy"}, bus.busy, b);
    chk({name, ".done"}, bus.done, dn);
    chk({name, ".zero"}, bus.zero, d == 0);
  endtask

  initial begin
    set_idle();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    cmp_en = 1;
    expect_out("reset", 8'h00, 0, 0, 0);

    bus.ld = 1; bus.data_in = 8'hFF; step();
    set_idle(); bus.inc = 1; step();
    expect_out("inc_wrap", 8'h00, 1, 0, 0);

    set_idle(); bus.dec = 1; step();
    expect_out("dec_borrow", 8'hFF, 1, 0, 0);
    step();
    expect_out("dec_plain", 8'hFE, 0, 0, 0);

    set_idle(); bus.ld = 1; bus.data_in = 8'h5A; step();
    bus.clr = 1; bus.inc = 1; bus.dec = 1; bus.shr = 1; bus.shl = 1; bus.start = 1;
    bus.shamt = 4'd2; step();
    expect_out("clr_wins", 8'h00, 0, 0, 0);
    set_idle(); bus.ld = 1; bus.inc = 1; bus.data_in = 8'h10; step();
    expect_out("ld_over_inc", 8'h10, 0, 0, 0);

    set_idle(); bus.ld = 1; bus.data_in = 8'h81; step();
    set_idle(); bus.start = 1; bus.shamt = 4'd3; bus.dir = 0; step();
    expect_out("ser_start", 8'h81, 0, 1, 0);
    bus.ld = 1; bus.inc = 1; bus.shl = 1; bus.data_in = 8'hAA; step();
    expect_out("ser_1", 8'h40, 1, 1, 0);
    step();
    expect_out("ser_2", 8'h20, 0, 1, 0);
    step();
    expect_out("ser_done", 8'h10, 0, 0, 1);
    set_idle(); step();
    expect_out("ser_after", 8'h10, 0, 0, 0);

    bus.ld = 1; bus.data_in = 8'h0F; step();
    set_idle(); bus.start = 1; bus.shamt = 4'd5; bus.dir = 1; bus.input_carry = 1; step();
    set_idle(); step();
    bus.clr = 1; step();
    expect_out("abort", 8'h00, 0, 0, 0);
    set_idle(); step();
    expect_out("abort_nodone", 8'h00, 0, 0, 0);

    bus.ld = 1; bus.data_in = 8'h3C; step();
    set_idle(); bus.start = 1; bus.shamt = 4'd0; step();
    expect_out("shamt0", 8'h3C, 0, 0, 1);
    set_idle(); step();
    expect_out("shamt0_after", 8'h3C, 0, 0, 0);

    bus.start = 1; bus.shamt = 4'd4; step();
    set_idle(); step();
    rst_n = 0; step();
    expect_out("rst_mid", 8'h00, 0, 0, 0);
    rst_n = 1;

    for (int i = 0; i < 3000; i++) begin
      bus.clr = ($urandom_range(0, 99) < 3);
      bus.ld  = ($urandom_range(0, 99) < 15);
      bus.inc = ($urandom_range(0, 99) < 20);
      bus.dec = ($urandom_range(0, 99) < 20);
      bus.shr = ($urandom_range(0, 99) < 20);
      bus.shl = ($urandom_range(0, 99) < 20);
      bus.start = ($urandom_range(0, 99) < 30);
      bus.shamt = ($urandom_range(0, 3) == 0) ? SW'($urandom_range(0, 15))
                                              : SW'($urandom_range(0, 3));
      bus.dir = 1'($urandom_range(0, 1));
      bus.input_carry = 1'($urandom_range(0, 1));
      bus.data_in = W'($urandom_range(0, 255));
`ifdef FULL_REGISTER_N_ROTATE_EN
      bus.rot = 1'($urandom_range(0, 1));
`endif
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1;
    set_idle();
    step();
    cmp_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
